iterative_lut_mult: RTL and testbench

//  Parametrised sequential multiplier built from a radix-4 LUT digit stage.

---
 rtl/lut_mult_pkg.sv | 27 ++
 rtl/radix4_lut_digit.sv | 30 +++
 rtl/iterative_lut_mult.sv | 130 +++++++++++++
 tb/tb_iterative_lut_mult.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lut_mult_pkg.sv
// Shared definitions for the iterative radix-4 LUT multiplier.
//   state_t     : FSM encoding (IDLE, CALC, DONE)
//   DIGIT_BITS  : bits of operand B consumed per CALC cycle
//   num_digits  : number of radix-4 digits in a WIDTH_B-bit multiplier
//   cnt_width   : width of the digit counter (at least 1 bit)
package lut_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DIGIT_BITS = 2;

   function automatic int unsigned num_digits(input int unsigned width_b);
      return width_b / DIGIT_BITS;
   endfunction

   // A single-digit multiplier still needs a 1-bit counter to stay legal.
   function automatic int unsigned cnt_width(input int unsigned width_b);
      int unsigned n;
      n = num_digits(width_b);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/radix4_lut_digit.sv
// Combinational radix-4 partial-product generator.
// Ports:
//   a  : multiplicand (WIDTH_A bits)
//   d  : radix-4 digit of the multiplier
//   pp : a * d (WIDTH_A+2 bits, cannot overflow)
module radix4_lut_digit #(
   parameter int unsigned WIDTH_A = 16
) (
   input  logic [WIDTH_A-1:0] a,
   input  logic [1:0]         d,
   output logic [WIDTH_A+1:0] pp
);

   logic [WIDTH_A+1:0] a_x1;
   logic [WIDTH_A+1:0] a_x2;

   assign a_x1 = {2'b00, a};
   assign a_x2 = {1'b0, a, 1'b0};

   always_comb begin
      pp = '0;
      unique case (d)
         2'd0: pp = '0;
         2'd1: pp = a_x1;
         2'd2: pp = a_x2;
         2'd3: pp = a_x2 + a_x1;
      endcase
   end

endmodule

// File: rtl/iterative_lut_mult.sv
// Sequential unsigned multiplier: consumes two bits of B per cycle and accumulates the
// radix-4 LUT partial product {0, A, 2A, 3A} shifted into place.
// Ports:
//   Clock   : rising-edge clock
//   Reset   : synchronous, active-high; drops any operation in flight
//   iStart  : request, sampled only in IDLE
//   iData_A : multiplicand, captured when start is accepted
//   iData_B : multiplier, captured when start is accepted
//   oBusy   : high in CALC and DONE
//   oDone   : one-cycle pulse, oResult valid
//   oResult : full-precision product, held until the next operation completes
// Configuration macro ITERATIVE_LUT_MULT_EARLY_TERM_EN: when defined, the operation finishes
// as soon as the remaining multiplier bits are all zero (variable latency, same result).
module iterative_lut_mult
   import lut_mult_pkg::*;
#(
   parameter int unsigned WIDTH_A = 16,
   parameter int unsigned WIDTH_B = 16
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       iStart,
   input  logic [WIDTH_A-1:0]         iData_A,
   input  logic [WIDTH_B-1:0]         iData_B,
   output logic                       oBusy,
   output logic                       oDone,
   output logic [WIDTH_A+WIDTH_B-1:0] oResult
);

   localparam int unsigned N     = num_digits(WIDTH_B);
   localparam int unsigned K_W   = cnt_width(WIDTH_B);
   localparam int unsigned ACC_W = WIDTH_A + WIDTH_B;

   if ((WIDTH_B % DIGIT_BITS) != 0 || WIDTH_B < 2 || WIDTH_A < 2) begin : g_bad_width
      $error("iterative_lut_mult: WIDTH_B must be even and >= 2, WIDTH_A must be >= 2");
   end

   state_t               state;
   logic [WIDTH_A-1:0]   a_reg;
   logic [WIDTH_B-1:0]   b_reg;
   logic [ACC_W-1:0]     acc;
   logic [K_W-1:0]       k;

   logic [WIDTH_A+1:0]   lut_pp;
   logic [ACC_W-1:0]     pp_shift;
   logic [ACC_W-1:0]     acc_next;
   logic [WIDTH_B-1:0]   b_next;
   logic                 last_digit;

   radix4_lut_digit #(
      .WIDTH_A (WIDTH_A)
   ) u_lut (
      .a  (a_reg),
      .d  (b_reg[1:0]),
      .pp (lut_pp)
   );

   always_comb begin
      // Digit k has weight 4^k, i.e. a left shift by 2k.
      pp_shift   = ACC_W'(lut_pp) << {k, 1'b0};
      acc_next   = acc + pp_shift;
      b_next     = b_reg >> DIGIT_BITS;
      last_digit = (k == K_W'(N - 1));
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         acc     <= '0;
         k       <= '0;
         oResult <= '0;
         oDone   <= 1'b0;
         oBusy   <= 1'b0;
      end else begin
         oDone <= 1'b0;
         case (state)
            IDLE: begin
               if (iStart) begin
                  a_reg <= iData_A;
                  b_reg <= iData_B;
                  acc   <= '0;
                  k     <= '0;
                  oBusy <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
`ifdef ITERATIVE_LUT_MULT_EARLY_TERM_EN
               if (b_reg == '0) begin
                  // Only reachable for B=0: nothing left to add.
                  oResult <= acc;
                  oDone   <= 1'b1;
                  state   <= DONE;
               end else begin
                  acc   <= acc_next;
                  b_reg <= b_next;
                  k     <= k + K_W'(1);
                  // Finish once the remaining multiplier digits are all zero.
                  if (last_digit || b_next == '0) begin
                     oResult <= acc_next;
                     oDone   <= 1'b1;
                     state   <= DONE;
                  end
               end
`else
               acc   <= acc_next;
               b_reg <= b_next;
               k     <= k + K_W'(1);
               if (last_digit) begin
                  oResult <= acc_next;
                  oDone   <= 1'b1;
                  state   <= DONE;
               end
`endif
            end
            DONE: begin
               oBusy <= 1'b0;
               state <= IDLE;
            end
            default: begin
               oBusy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_lut_mult.sv
// Directed and random checks of iterative_lut_mult at the default 16x16 size.
// Expected latencies follow the build: ITERATIVE_LUT_MULT_EARLY_TERM_EN selects the
// variable-latency expectation.
module tb_iterative_lut_mult;

   localparam int LIMIT = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] da;
   logic [15:0] db;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   iterative_lut_mult #(
      .WIDTH_A (16),
      .WIDTH_B (16)
   ) dut (
      .Clock   (clk),
      .Reset   (rst),
      .iStart  (start),
      .iData_A (da),
      .iData_B (db),
      .oBusy   (busy),
      .oDone   (done),
      .oResult (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
      string       tag;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // CALC edges from the accepted start edge to the edge that raises oDone.
   function automatic int exp_lat(input logic [15:0] b);
`ifdef ITERATIVE_LUT_MULT_EARLY_TERM_EN
      int hi;
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[2*i +: 2] != 2'd0) hi = i;
      end
      return hi + 1;
`else
      return 8;
`endif
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < LIMIT) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p,
                        input string tag);
      int lat;
      @(negedge clk);
      start = 1'b1;
      da    = a;
      db    = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      da    = ~a;  // operands must no longer matter
      db    = ~b;
      check({tag, " busy"}, 64'(busy), 64'(1));
      wait_done(lat);
      check({tag, " result"}, 64'(result), 64'(p));
      check({tag, " latency"}, 64'(lat), 64'(exp_lat(b)));
      @(posedge clk);
      #1;
      check({tag, " pulse"}, 64'({done, busy}), 64'(0));
   endtask

   initial begin
      int lat;
      int lat2;
      int seen;
      logic [15:0] ra;
      logic [15:0] rb;

      vecs[0] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE0001, tag: "max"};
      vecs[1] = '{a: 16'h0003, b: 16'h0005, p: 32'h0000000F, tag: "3x5"};
      vecs[2] = '{a: 16'h1234, b: 16'h0000, p: 32'h00000000, tag: "b0"};
      vecs[3] = '{a: 16'hABCD, b: 16'h0003, p: 32'h00020367, tag: "b3"};
      vecs[4] = '{a: 16'h0001, b: 16'h8000, p: 32'h00008000, tag: "b8000"};
      vecs[5] = '{a: 16'h00FF, b: 16'h0100, p: 32'h0000FF00, tag: "ffx100"};
      vecs[6] = '{a: 16'h8000, b: 16'h8000, p: 32'h40000000, tag: "msb"};

      rst   = 1'b1;
      start = 1'b0;
      da    = '0;
      db    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset result", 64'(result), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].tag);
      end

      // iStart held high with operands changed mid-CALC.
      @(negedge clk);
      start = 1'b1;
      da    = 16'd5;
      db    = 16'd7;
      @(posedge clk);
      #1;
      da = 16'd9;
      db = 16'd11;
      wait_done(lat);
      check("held first result", 64'(result), 64'(35));
      check("held first latency", 64'(lat), 64'(exp_lat(16'd7)));
      wait_done(lat2);
      // lat2 starts with done still high, so step once before waiting.
      if (lat2 == 0) begin
         @(posedge clk);
         #1;
         wait_done(lat2);
         lat2++;
      end
      check("held second result", 64'(result), 64'(99));
      check("held second latency", 64'(lat2), 64'(exp_lat(16'd11) + 2));
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("held pulse", 64'(done), 64'(0));

      // Reset in the third CALC cycle drops the operation.
      @(negedge clk);
      start = 1'b1;
      da    = 16'h1234;
      db    = 16'h5678;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst busy", 64'(busy), 64'(0));
      check("midrst done", 64'(done), 64'(0));
      check("midrst result", 64'(result), 64'(0));
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check("midrst no done", 64'(seen), 64'(0));
      do_op(16'h1234, 16'h5678, 32'h06260060, "after rst");

      for (int i = 0; i < 100; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 4 == 0) rb = rb & 16'h00F0;
         do_op(ra, rb, 32'(ra) * 32'(rb), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
